// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_pkg
// Description : Shared ALU adder types: op encoding, flag bundle, chunk width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

  // Adder operation selected by sub_in.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } adder_op_e;

  // Condition flags produced alongside the result when flags are enabled.
  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
  } adder_flags_t;

  // Width of one carry-chained chunk, one chunk per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : adder_chunk
// Description : Combinational CW-bit adder slice with carry in/out and the
//               carry into its MSB (used for signed overflow detection).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_chunk #(
  parameter int CW = 32
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          carry_i,
  output logic [CW-1:0] sum_o,
  output logic          carry_o,
  output logic          carry_msb_o
);

  logic [CW:0] w_full;

  // One extra bit captures the carry out of the slice.
  assign w_full      = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
  assign sum_o       = w_full[CW-1:0];
  assign carry_o     = w_full[CW];
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign carry_msb_o = a_i[CW-1] ^ b_i[CW-1] ^ w_full[CW-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit add/subtract split into STAGES carry-chained chunks,
//               one chunk per stage, valid/ready handshake with full
//               backpressure. Optional flag outputs under ADDER_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] operand1_in,
  input  logic [WIDTH-1:0] operand2_in,
  input  logic             sub_in,
  input  logic             carry_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out
`ifdef ADDER_FLAGS_EN
  ,
  output logic             zero_out,
  output logic             negative_out,
  output logic             overflow_out
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // Per-stage registers: operands still to be consumed, partial result,
  // chunk carry and valid bit.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;

  // Per-stage combinational inputs and chunk outputs.
  logic [WIDTH-1:0]  w_a   [STAGES];
  logic [WIDTH-1:0]  w_b   [STAGES];
  logic [WIDTH-1:0]  w_res [STAGES];
  logic [CW-1:0]     w_sum [STAGES];
  logic [STAGES-1:0] w_c;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_cmsb;

  logic      w_adv;
  adder_op_e w_op;

  // The whole pipe moves as one; no bubble collapsing.
  assign w_adv         = !out_valid_out || out_ready_in;
  assign in_ready_out  = w_adv;
  assign w_op          = sub_in ? OP_SUB : OP_ADD;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_merge;

    if (k == 0) begin : g_head
      // Subtraction becomes op1 + ~op2 + 1 before entering the pipe.
      assign w_a[k]   = operand1_in;
      assign w_b[k]   = (w_op == OP_SUB) ? ~operand2_in : operand2_in;
      assign w_res[k] = '0;
      assign w_c[k]   = (w_op == OP_SUB) ? 1'b1 : carry_in;
      assign w_v[k]   = in_valid_in;
    end else begin : g_body
      assign w_a[k]   = a_q[k-1];
      assign w_b[k]   = b_q[k-1];
      assign w_res[k] = res_q[k-1];
      assign w_c[k]   = carry_q[k-1];
      assign w_v[k]   = valid_q[k-1];
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i        (w_a[k][k*CW +: CW]),
      .b_i        (w_b[k][k*CW +: CW]),
      .carry_i    (w_c[k]),
      .sum_o      (w_sum[k]),
      .carry_o    (w_cout[k]),
      .carry_msb_o(w_cmsb[k])
    );

    // Insert this stage's chunk into the partial result travelling down.
    always_comb begin
      w_merge              = w_res[k];
      w_merge[k*CW +: CW]  = w_sum[k];
    end
    assign res_d[k] = w_merge;
  end

  // All stages shift together on advance and hold otherwise.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= w_a[k];
        b_q[k]   <= w_b[k];
        res_q[k] <= res_d[k];
      end
      carry_q <= w_cout;
      valid_q <= w_v;
    end
  end

  assign result_out    = res_q[STAGES-1];
  assign carry_out     = carry_q[STAGES-1];
  assign out_valid_out = valid_q[STAGES-1];

`ifdef ADDER_FLAGS_EN
  adder_flags_t flags_d;
  adder_flags_t flags_q;

  // Flags derive from the completed result in the last stage.
  always_comb begin
    flags_d.zero     = (res_d[STAGES-1] == '0);
    flags_d.negative = res_d[STAGES-1][WIDTH-1];
    flags_d.overflow = w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
  end

  // Flags register with the last stage so they stay aligned with the result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      flags_q <= '0;
    end else if (w_adv) begin
      flags_q <= flags_d;
    end
  end

  assign zero_out     = flags_q.zero;
  assign negative_out = flags_q.negative;
  assign overflow_out = flags_q.overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Self-checking bench for pipelined_adder (64/2, 32/4, 32/1).
//               Flag checks are active when ADDER_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Main 64-bit, 2-stage instance.
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [63:0] m_op1, m_op2, m_res;
  logic        m_sub, m_cin, m_cout;
  logic        m_zero, m_neg, m_ovf;

  // Shared stimulus for the two 32-bit instances.
  logic        s_valid, s_sub, s_cin, s_out_ready;
  logic [31:0] s_op1, s_op2;
  logic        q4_in_ready, q4_out_valid, q4_cout;
  logic [31:0] q4_res;
  logic        q1_in_ready, q1_out_valid, q1_cout;
  logic [31:0] q1_res;
  logic        q4_z, q4_n, q4_o, q1_z, q1_n, q1_o;

  typedef struct {
    int          cyc;
    logic [64:0] val;
    logic [2:0]  flg;
  } exp_t;

  pipelined_adder #(.WIDTH(64), .STAGES(2)) u_m (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid_in(m_in_valid), .in_ready_out(m_in_ready),
    .operand1_in(m_op1), .operand2_in(m_op2),
    .sub_in(m_sub), .carry_in(m_cin),
    .out_valid_out(m_out_valid), .out_ready_in(m_out_ready),
    .result_out(m_res), .carry_out(m_cout)
`ifdef ADDER_FLAGS_EN
    , .zero_out(m_zero), .negative_out(m_neg), .overflow_out(m_ovf)
`endif
  );

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid_in(s_valid), .in_ready_out(q4_in_ready),
    .operand1_in(s_op1), .operand2_in(s_op2),
    .sub_in(s_sub), .carry_in(s_cin),
    .out_valid_out(q4_out_valid), .out_ready_in(s_out_ready),
    .result_out(q4_res), .carry_out(q4_cout)
`ifdef ADDER_FLAGS_EN
    , .zero_out(q4_z), .negative_out(q4_n), .overflow_out(q4_o)
`endif
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid_in(s_valid), .in_ready_out(q1_in_ready),
    .operand1_in(s_op1), .operand2_in(s_op2),
    .sub_in(s_sub), .carry_in(s_cin),
    .out_valid_out(q1_out_valid), .out_ready_in(s_out_ready),
    .result_out(q1_res), .carry_out(q1_cout)
`ifdef ADDER_FLAGS_EN
    , .zero_out(q1_z), .negative_out(q1_n), .overflow_out(q1_o)
`endif
  );

  // Reference: {carry, result} of op1 + op2 + cin, or op1 - op2 as op1 + ~op2 + 1.
  function automatic logic [64:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                        input logic sub, input logic cin);
    logic [63:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
  endfunction

  // Reference flags {zero, negative, overflow}; overflow = same-sign inputs, other-sign result.
  function automatic logic [2:0] flags64(input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin);
    logic [64:0] r;
    logic [63:0] bb;
    r  = ref64(a, b, sub, cin);
    bb = sub ? ~b : b;
    return {(r[63:0] == 64'd0), r[63], (a[63] == bb[63]) && (r[63] != a[63])};
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", m_out_valid); end
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", m_in_ready); end
    checks++; if (m_res !== 64'd0 || m_cout !== 1'b0) begin errors++; $display("FAIL rst_result: got %h/%b want 0/0", m_res, m_cout); end
    checks++; if (q4_out_valid !== 1'b0 || q1_out_valid !== 1'b0) begin errors++; $display("FAIL rst_sweep_valid: got %b%b want 00", q4_out_valid, q1_out_valid); end
`ifdef ADDER_FLAGS_EN
    checks++; if ({m_zero, m_neg, m_ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {m_zero, m_neg, m_ovf}); end
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_directed(input logic [63:0] a, input logic [63:0] b, input logic sub,
                               input logic cin, input logic [63:0] er, input logic ec,
                               input logic [2:0] ef, input int id);
    @(posedge clk); #1;
    m_op1 = a; m_op2 = b; m_sub = sub; m_cin = cin;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    m_op1 = ~a; m_op2 = ~b;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early: valid got %b want 0", id, m_out_valid); end
    @(posedge clk); #1;
    checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: valid got %b want 1", id, m_out_valid); end
    checks++; if (m_res !== er || m_cout !== ec) begin errors++; $display("FAIL dir%0d_result: got %h/%b want %h/%b", id, m_res, m_cout, er, ec); end
`ifdef ADDER_FLAGS_EN
    checks++; if ({m_zero, m_neg, m_ovf} !== ef) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", id, {m_zero, m_neg, m_ovf}, ef); end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0;
    logic        pend = 1'b0, stall = 1'b0, acc, drn;
    logic [63:0] sres;
    logic        scout;
    logic [2:0]  sflg;
    while ((sent < 100 || got < 100) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (stall) begin
        checks++;
        if (m_out_valid !== 1'b1 || m_res !== sres || m_cout !== scout) begin
          errors++; $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b", m_out_valid, m_res, m_cout, sres, scout);
        end
`ifdef ADDER_FLAGS_EN
        checks++;
        if ({m_zero, m_neg, m_ovf} !== sflg) begin errors++; $display("FAIL stall_flags: got %b want %b", {m_zero, m_neg, m_ovf}, sflg); end
`endif
      end
      if (!pend && sent < 100 && ($urandom % 4) != 0) begin
        m_op1 = {$urandom, $urandom};
        m_op2 = (($urandom % 8) == 0) ? ~m_op1 : {$urandom, $urandom};
        m_sub = 1'($urandom % 2);
        m_cin = 1'($urandom % 2);
        pend  = 1'b1;
      end
      m_in_valid  = pend;
      m_out_ready = 1'($urandom % 2);
      #1;
      checks++;
      if (m_in_ready !== (!m_out_valid || m_out_ready)) begin
        errors++; $display("FAIL ready_rule: got %b want %b", m_in_ready, (!m_out_valid || m_out_ready));
      end
      acc = m_in_valid && m_in_ready;
      drn = m_out_valid && m_out_ready;
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL extra_result: got %h want none", m_res);
        end else begin
          e = q.pop_front();
          if ({m_cout, m_res} !== e.val) begin
            errors++; $display("FAIL b2b_result_%0d: got %b/%h want %b/%h", got, m_cout, m_res, e.val[64], e.val[63:0]);
          end
`ifdef ADDER_FLAGS_EN
          checks++;
          if ({m_zero, m_neg, m_ovf} !== e.flg) begin errors++; $display("FAIL b2b_flags_%0d: got %b want %b", got, {m_zero, m_neg, m_ovf}, e.flg); end
`endif
          got++;
        end
      end
      if (acc) begin
        e.cyc = cyc;
        e.val = ref64(m_op1, m_op2, m_sub, m_cin);
        e.flg = flags64(m_op1, m_op2, m_sub, m_cin);
        q.push_back(e);
        sent++;
        pend = 1'b0;
      end
      stall = m_out_valid && !m_out_ready;
      sres  = m_res;
      scout = m_cout;
      sflg  = {m_zero, m_neg, m_ovf};
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    checks++;
    if (got != 100 || q.size() != 0 || sent != 100) begin
      errors++; $display("FAIL b2b_count: got %0d results, %0d pending, want 100 and 0", got, q.size());
    end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    m_op1 = 64'h1111; m_op2 = 64'h2222; m_sub = 1'b0; m_cin = 1'b0;
    m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_op1 = 64'h3333;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL inflight_setup: valid got %b want 1", m_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", m_out_valid); end
    checks++; if (m_res !== 64'd0 || m_cout !== 1'b0) begin errors++; $display("FAIL async_rst_result: got %h/%b want 0/0", m_res, m_cout); end
    checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b want 1", m_in_ready); end
    @(posedge clk); #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b want 0", m_out_valid); end
    #2 rst_n = 1'b1;
    m_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_out_valid !== 1'b0) begin errors++; $display("FAIL stale_after_reset_%0d: valid got %b want 0", i, m_out_valid); end
    end
  endtask

  task automatic test_sweep();
    exp_t q4[$];
    exp_t q1[$];
    exp_t e;
    int   cyc = 0, fed = 0;
    for (int it = 0; it < 60; it++) begin
      @(posedge clk); #1;
      cyc++;
      if (q1_out_valid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL s1_extra: got %h want none", q1_res);
        end else begin
          e = q1.pop_front();
          if ({q1_cout, q1_res} !== e.val[32:0]) begin errors++; $display("FAIL s1_result: got %b/%h want %b/%h", q1_cout, q1_res, e.val[32], e.val[31:0]); end
          checks++;
          if (cyc - e.cyc != 0) begin errors++; $display("FAIL s1_latency: got %0d want 0", cyc - e.cyc); end
        end
      end
      if (q4_out_valid) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("FAIL s4_extra: got %h want none", q4_res);
        end else begin
          e = q4.pop_front();
          if ({q4_cout, q4_res} !== e.val[32:0]) begin errors++; $display("FAIL s4_result: got %b/%h want %b/%h", q4_cout, q4_res, e.val[32], e.val[31:0]); end
          checks++;
          if (cyc - e.cyc != 3) begin errors++; $display("FAIL s4_latency: got %0d want 3", cyc - e.cyc); end
        end
      end
      if (fed < 40) begin
        s_valid = 1'b1;
        s_op1   = $urandom;
        s_op2   = (($urandom % 8) == 0) ? ~s_op1 : $urandom;
        s_sub   = 1'($urandom % 2);
        s_cin   = 1'($urandom % 2);
        fed++;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      e.cyc = cyc + 1;
      e.val = {32'd0, ref32(s_op1, s_op2, s_sub, s_cin)};
      e.flg = 3'b000;
      if (s_valid && q1_in_ready) q1.push_back(e);
      if (s_valid && q4_in_ready) q4.push_back(e);
    end
    s_valid = 1'b0;
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++; $display("FAIL sweep_drain: got %0d/%0d pending want 0/0", q1.size(), q4.size());
    end
  endtask

  initial begin
    m_in_valid = 1'b0; m_out_ready = 1'b1; m_op1 = '0; m_op2 = '0; m_sub = 1'b0; m_cin = 1'b0;
    s_valid = 1'b0; s_out_ready = 1'b1; s_op1 = '0; s_op2 = '0; s_sub = 1'b0; s_cin = 1'b0;
`ifndef ADDER_FLAGS_EN
    m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
    q4_z = 1'b0; q4_n = 1'b0; q4_o = 1'b0; q1_z = 1'b0; q1_n = 1'b0; q1_o = 1'b0;
`endif
    test_reset();
    test_directed(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 3'b000, 1);
    test_directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 3'b100, 2);
    test_directed(64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b010, 3);
    test_directed(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, 4);
    test_directed(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 3'b000, 5);
    test_directed(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 3'b000, 6);
    test_back_to_back();
    test_reset_inflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
